// File: rtl/mont_to_plain.sv
// mont_to_plain: bit-serial radix-2 Montgomery reduction.
// Converts a Montgomery-domain operand back to plain residue form:
//   result = a_mont * 2^(-BITS) mod N
// Optional build macro: MONT_TO_PLAIN_FINAL_SUB_EN
//   defined   -> extra FINAL state with compare/subtract; accepts a_mont < 2N
//   undefined -> no subtractor, one cycle shorter; requires a_mont < N
// The instantiating level passes the datapath width shared across mod_exp.

module mont_to_plain #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] a_mont,
  input  logic [BITS-1:0] N,
  output logic            finish,
  output logic [BITS-1:0] result
);

  // Accumulator carries two guard bits: T stays below 2N, so T + N stays
  // below 3N < 2^(BITS+2) and the add never drops a carry.
  localparam int TW = BITS + 2;
  // Counter must hold values up to BITS.
  localparam int CW = (BITS < 2) ? 1 : $clog2(BITS + 1);

`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FINAL  = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [BITS-1:0] nq_q, nq_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] result_q, result_d;
  logic            finish_q, finish_d;

  // Datapath helpers shared by the next-state logic.
  logic [TW-1:0]   t_sum;
  logic [TW-1:0]   t_half;
  logic            last_iter;
`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
  logic [BITS-1:0] t_diff;
  logic            t_ge_n;
`endif

  // One reduction step: add N when T is odd so the low bit clears, then halve.
  always_comb begin
    t_sum     = t_q + (t_q[0] ? {2'b00, nq_q} : {TW{1'b0}});
    t_half    = t_sum >> 1;
    last_iter = (cnt_q == CW'(BITS - 1));
`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
    // The compare uses the full-width T; the difference only needs the low
    // BITS bits because, when taken, it is always below N.
    t_ge_n    = (t_q >= {2'b00, nq_q});
    t_diff    = t_q[BITS-1:0] - nq_q;
`endif
  end

  // Next-state and output logic; everything holds unless a state says otherwise.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    nq_d     = nq_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    finish_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          t_d     = {2'b00, a_mont};
          nq_d    = N;
          cnt_d   = '0;
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        t_d   = t_half;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
          state_d = FINAL;
`else
          // Without the correction stage the last halving is the answer.
          result_d = t_half[BITS-1:0];
          finish_d = 1'b1;
          state_d  = IDLE;
`endif
        end
      end

`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
      FINAL: begin
        // T < 2N here, so a single conditional subtract fully reduces it.
        result_d = t_ge_n ? t_diff : t_q[BITS-1:0];
        finish_d = 1'b1;
        state_d  = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any conversion and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      nq_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      nq_q     <= nq_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      finish_q <= finish_d;
    end
  end

  assign finish = finish_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_to_plain.sv
// Testbench for mont_to_plain (BITS = 16).
// Stimulus pushes {expected result, expected finish cycle} into a queue; a
// negedge monitor pops and checks whenever finish is high, and also checks
// that result holds its value between finishes and clears on reset.
// Honours MONT_TO_PLAIN_FINAL_SUB_EN for latency and the final-subtract cases.

module tb_mont_to_plain;

  localparam int BITS = 16;
`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
  localparam int LAT = BITS + 1;
`else
  localparam int LAT = BITS;
`endif
  localparam logic [BITS-1:0] NMAX = 16'hFFFF;

  logic            clk;
  logic            rst;
  logic            start;
  logic [BITS-1:0] a_mont;
  logic [BITS-1:0] n_in;
  logic            finish;
  logic [BITS-1:0] result;

  mont_to_plain #(.BITS(BITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_mont (a_mont),
    .N      (n_in),
    .finish (finish),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] val;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];

  int  cyc = 0;
  bit  rst_s = 1'b1;
  bit  done = 1'b0;
  int  compared = 0;
  int  mismatched = 0;
  logic [BITS-1:0] held = '0;

  // Cycle index of the most recent rising edge, and whether that edge saw reset.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_s) begin
      held = '0;
      compared++;
      if (finish !== 1'b0 || result !== '0) begin
        mismatched++;
        $display("FAIL reset_state: finish=%b result=%h, required finish=0 result=0", finish, result);
      end
    end else if (finish === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_finish: cycle %0d result=%h, no finish required", cyc, result);
      end else begin
        e = exp_q.pop_front();
        compared++;
        if (result !== e.val) begin
          mismatched++;
          $display("FAIL result: got %h, required %h", result, e.val);
        end
        compared++;
        if (cyc != e.cyc) begin
          mismatched++;
          $display("FAIL latency: finish at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
        $display("txn: finish cycle %0d result=%h expected=%h", cyc, result, e.val);
        held = e.val;
      end
    end else begin
      compared++;
      if (result !== held || finish !== 1'b0) begin
        mismatched++;
        $display("FAIL hold: result=%h finish=%b, required result=%h finish=0", result, finish, held);
      end
    end

    if (done || cyc > 20000) begin
      compared++;
      if (exp_q.size() != 0 || !done) begin
        mismatched++;
        $display("FAIL pending: %0d finishes outstanding (timeout=%0d), required 0", exp_q.size(), !done);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  // Drive a start just after a rising edge; returns just after edge E0 with
  // start dropped. Pushes the expected result and the finish cycle E0+LAT.
  task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] n,
                       input logic [BITS-1:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    a_mont = a;
    n_in   = n;
    start  = 1'b1;
    e.val  = expv;
    e.cyc  = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    a_mont = ~a;
    n_in   = ~n;
  endtask

  task automatic run(input logic [BITS-1:0] a, input logic [BITS-1:0] n,
                     input logic [BITS-1:0] expv);
    issue(a, n, expv);
    repeat (LAT) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    logic [BITS-1:0] rn, rx, ra;
    longint unsigned wide;

    rst    = 1'b1;
    start  = 1'b0;
    a_mont = '0;
    n_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity and zero with N = 2^BITS-1 (R mod N = 1).
    run(16'd5, NMAX, 16'd5);
    run(16'd0, NMAX, 16'd0);
    run(16'd1234, NMAX, 16'd1234);

`ifdef MONT_TO_PLAIN_FINAL_SUB_EN
    // a_mont = N reduces to 0; N-1 is the control.
    run(NMAX, NMAX, 16'd0);
    run(16'hFFFE, NMAX, 16'hFFFE);
    // Unreduced input: 3*R mod 0x8001 = 0x7FFB, plus N = 0xFFFC -> 3.
    run(16'hFFFC, 16'h8001, 16'd3);
    // Same residue, reduced form.
    run(16'h7FFB, 16'h8001, 16'd3);
`endif

    // Generic odd moduli: a_mont = x*R mod N must return x.
    for (int i = 0; i < 50; i++) begin
      rn   = BITS'($urandom_range(0, 65535)) | 16'h8001;
      rx   = BITS'($urandom_range(0, int'(rn) - 1));
      wide = (longint'(rx) << BITS) % longint'(rn);
      ra   = BITS'(wide);
      run(ra, rn, rx);
    end

    // Busy start: a second request during REDUCE is dropped.
    issue(16'd5, NMAX, 16'd5);
    repeat (3) @(posedge clk);
    #1;
    a_mont = 16'd77;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    repeat (LAT - 4) @(posedge clk);

    // Back-to-back: start held high across two operations.
    @(posedge clk);
    #1;
    a_mont = 16'd7;
    n_in   = NMAX;
    start  = 1'b1;
    e.val  = 16'd7;
    e.cyc  = cyc + 1 + LAT;
    exp_q.push_back(e);
    e.val  = 16'd9;
    e.cyc  = cyc + 1 + LAT + 1 + LAT;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a_mont = 16'd9;
    repeat (LAT + 1) @(posedge clk);
    #1;
    start  = 1'b0;
    repeat (LAT) @(posedge clk);

    // Reset at iteration 10: no finish, result cleared, back to IDLE.
    @(posedge clk);
    #1;
    a_mont = 16'd123;
    n_in   = NMAX;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);

    run(16'd4, NMAX, 16'd4);

    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
